// File: rtl/shift_reg_framer.sv
// shift_reg_framer: parallel-load shift register with serial in/out,
// ready/valid load handshake, bit strobe, abort and frame-done pulse.
module shift_reg_framer #(
  parameter int WIDTH = 18,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load_Valid,
  output logic             Load_Ready,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Shift_In,
  input  logic             Abort,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] Data_Out,
  output logic [CNT_W-1:0] Bit_Cnt,
  output logic             Busy,
  output logic             Frame_Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  logic [WIDTH-1:0] w_shifted;
  logic             w_last;
  logic             w_so;

  always_comb begin
    w_shifted = r_data;
    if (MSB_FIRST)
      w_shifted = {r_data[WIDTH-2:0], Shift_In};
    else
      w_shifted = {Shift_In, r_data[WIDTH-1:1]};
  end

  assign w_last = (r_cnt == LAST_CNT);
  assign w_so   = MSB_FIRST ? r_data[WIDTH-1] : r_data[0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Load_Valid) begin
            r_data  <= D;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_SHIFT: begin
          // abort keeps the partial word and count visible
          if (Abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else if (Shift_En) begin
            r_data <= w_shifted;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (Load_Valid) begin
            r_data  <= D;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign Load_Ready = r_ready;
  assign Shift_Out  = w_so;
  assign Data_Out   = r_data;
  assign Bit_Cnt    = r_cnt;
  assign Busy       = r_busy;
  assign Frame_Done = r_done;

endmodule
